spi_frame_rx: RTL and testbench
===============================

Name: spi_frame_rx

Overview:
- Upstream front end for the SPI register bank, which in turn drives the PWM/output stage.
- Brings the asynchronous SPI pins (SCLK, COPI, nCS) into the clk domain and deserializes 16-bit mode-0 frames.
- On each valid write frame, emits a one-cycle register-write strobe with address and data.
- Reports malformed frames. Performs no register storage itself.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per SPI input (min 2).
- MAX_ADDR, 4, highest writable register address; writes above it are dropped.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- sclk_in  input  1  raw SPI clock pin, asynchronous.
- copi_in  input  1  raw SPI data pin, asynchronous.
- ncs_in  input  1  raw SPI chip select, active low, asynchronous.
- wr_valid  output  1  one-cycle write strobe.
- wr_addr  output  7  register address, held until the next wr_valid.
- wr_data  output  8  register data, held until the next wr_valid.
- frame_err  output  1  one-cycle pulse on a malformed write or read frame.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - Synchronizer chains reset to idle pin levels: ncs=1, sclk=0, copi=0.
  - Edge-history flops match those levels. FSM in IDLE, bit counter 0, shift register 0.
- Synchronization and edge detection:
  - Each input passes through a SYNC_STAGES flop chain, followed by one history flop.
  - Edge = synced value vs history value, combinational.
  - COPI uses the same depth, so COPI is sampled in the same cycle the SCLK rise is detected.
- Timing requirement: SCLK high and low phases are each ≥ 2 clk periods. nCS high time between frames is ≥ 2 clk periods.
- Frame format:
  - MSB first, sampled on SCLK rising edge (mode 0).
  - Bit15 = R/W (1 = write), bits14:8 = addr, bits7:0 = data.
- FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT on synced nCS falling edge: clear bit counter and shift register.
  - SHIFT, on each SCLK rise: shift in COPI; counter increments and saturates at 17.
  - SHIFT -> IDLE on synced nCS rising edge, with frame evaluation in that cycle.
- Frame evaluation (outputs are registered and take effect on the next clk edge):
  - count==16, R/W=1, addr ≤ MAX_ADDR: wr_valid=1 for exactly one cycle; wr_addr/wr_data load the frame fields.
  - count==16, R/W=0 (read): no strobe, no error.
  - count==16, addr > MAX_ADDR: silently dropped.
  - count≠16 (short, long, or 0 bits): frame_err=1 for one cycle. wr_addr/wr_data unchanged.
- Latency: wr_valid/frame_err rise at the (SYNC_STAGES+1)-th clk edge after the edge that first samples ncs_in high. That is 3 edges at the default.
- busy: 1 in SHIFT, 0 in IDLE (registered with state).
- Simultaneous events:
  - nCS fall and SCLK rise detected in the same cycle: nCS fall wins; that SCLK edge is not counted.
  - nCS rise and SCLK rise in the same cycle: SCLK edge ignored; evaluate with the current count.
- SCLK edges in IDLE (nCS high): ignored.
- nCS rise in IDLE: no output activity.
- rst mid-frame:
  - Frame discarded, FSM to IDLE.
  - If nCS is still low after reset, the block waits for the next nCS falling edge. The subsequent nCS rise produces no pulse and no error.
- rst has priority over all events in the same cycle.

Decomposition:
- Package spi_frame_pkg holds:
  - ADDR_W=7, DATA_W=8, FRAME_BITS=16, CNT_SAT=17.
  - The state enum {IDLE, SHIFT}.
  - Field bit positions RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8.
- Sub-module sync_edge_det: SYNC_STAGES synchronizer plus history flop, with outputs level, rise, fall and a reset-value parameter. Instantiated three times.
- FSM, counter and shift register stay in spi_frame_rx.

Test Plan:
- Write frame 0x80FF (write, addr 0x00, data 0xFF), SCLK = clk/8 -> wr_valid exactly one cycle, wr_addr=0x00, wr_data=0xFF, frame_err=0. Strobe lands 3 clk edges after nCS high is first sampled.
- Write 0x84A5 (addr 0x04, data 0xA5), then read frame 0x0233 -> one strobe with addr 0x04 / data 0xA5; no strobe or error for the read; outputs still 0x04/0xA5.
- 12-bit frame, then 17-bit frame -> frame_err one cycle each, wr_valid never asserted, wr_addr/wr_data unchanged from the previous write.
- Write 0x8511 (addr 0x05 > MAX_ADDR) -> no wr_valid, no frame_err.
- Assert rst after 8 bits of 0x8133 with nCS held low, release, finish the clocks, raise nCS -> no pulse, no error. Next full frame 0x8133 -> wr_valid, addr 0x01, data 0x33.
- Back-to-back frames 0x8001 and 0x8102 with nCS high for 2 clk -> two strobes in order, busy drops between frames, correct addr/data each.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// -----------------------------------------------------------------------------
// spi_frame_pkg
//   Shared constants and types for the SPI frame receiver.
//   - Frame geometry: 16-bit frames, MSB first, R/W flag in bit 15,
//     7-bit register address in bits 14:8, 8-bit data in bits 7:0.
//   - The bit counter saturates one past a full frame, so any frame
//     longer than 16 bits can be told apart from an exact one.
// -----------------------------------------------------------------------------
package spi_frame_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 16;
    localparam int CNT_SAT    = 17;
    localparam int CNT_W      = $clog2(CNT_SAT + 1);

    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage : spi_frame_pkg

// File: rtl/spi_frame_rx_sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
//   Brings one asynchronous pin into the clk domain through a SYNC_STAGES
//   flop chain, then compares the synchronized level with a one-cycle
//   history flop to produce single-cycle rise/fall indications.
//   Every flop resets to RESET_VAL, the idle level of the pin, so no edge
//   is reported while the pin stays at that level.
//
//   Ports:
//     clk   in   system clock
//     rst   in   synchronous, active-high reset
//     din   in   raw asynchronous pin
//     level out  synchronized pin level
//     rise  out  level went 0 -> 1 (combinational, one cycle)
//     fall  out  level went 1 -> 0 (combinational, one cycle)
// -----------------------------------------------------------------------------
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // NOTE: sequential state is always written with non-blocking (<=)
    // assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  =  level & ~hist_q;
    assign fall  = ~level &  hist_q;

endmodule : sync_edge_det

// File: rtl/spi_frame_rx.sv
// -----------------------------------------------------------------------------
// spi_frame_rx
//   SPI mode-0 frame receiver feeding the register bank. Synchronizes
//   SCLK/COPI/nCS into clk, shifts in 16-bit MSB-first frames on SCLK rising
//   edges while nCS is low, and evaluates the frame when nCS rises:
//     - exactly 16 bits, write, addr <= MAX_ADDR : one-cycle wr_valid
//     - exactly 16 bits, read or addr > MAX_ADDR : silently ignored
//     - any other bit count                      : one-cycle frame_err
//
//   Ports:
//     clk       in   system clock
//     rst       in   synchronous, active-high reset
//     sclk_in   in   raw SPI clock pin (async)
//     copi_in   in   raw SPI data pin (async)
//     ncs_in    in   raw SPI chip select, active low (async)
//     wr_valid  out  one-cycle register write strobe
//     wr_addr   out  write address, held until the next wr_valid
//     wr_data   out  write data, held until the next wr_valid
//     frame_err out  one-cycle pulse on a frame of the wrong length
//     busy      out  high while a frame is being shifted in
// -----------------------------------------------------------------------------
module spi_frame_rx
    import spi_frame_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              copi_in,
    input  logic              ncs_in,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    output logic              busy
);

    // -------------------------------------------------------------------------
    // Pin synchronization. COPI uses the same depth as SCLK so its level is
    // aligned with the cycle in which the SCLK rise is seen.
    // -------------------------------------------------------------------------
    logic ncs_level,  ncs_rise,  ncs_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic copi_level, copi_rise, copi_fall;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (ncs_in),
        .level (ncs_level),
        .rise  (ncs_rise),
        .fall  (ncs_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sclk_in),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_copi_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (copi_in),
        .level (copi_level),
        .rise  (copi_rise),
        .fall  (copi_fall)
    );

    // Only the nCS edges, the SCLK rise and the COPI level are used.
    logic unused_sync;
    assign unused_sync = &{1'b0, ncs_level, sclk_level, sclk_fall, copi_rise, copi_fall};

    // -------------------------------------------------------------------------
    // Post-reset blanking. The nCS chain resets to the idle level (high), so
    // if the pin is still low when reset is released the chain drains to 0
    // and reports a fake falling edge SYNC_STAGES cycles later. Ignoring nCS
    // falls until the chain has drained makes the block wait for a genuine
    // frame start instead of adopting the tail of an interrupted frame.
    // -------------------------------------------------------------------------
    localparam int                 BLANK_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'(SYNC_STAGES + 1);

    logic [BLANK_W-1:0] blank_q;
    logic               frame_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= BLANK_INIT;
        end else if (blank_q != '0) begin
            blank_q <= blank_q - BLANK_W'(1);
        end
    end

    assign frame_start = ncs_fall && (blank_q == '0);

    // -------------------------------------------------------------------------
    // FSM: state register / next-state logic / output decode
    // -------------------------------------------------------------------------
    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // so no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = SHIFT;
            SHIFT:   if (ncs_rise)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic [CNT_W-1:0]      cnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [ADDR_W-1:0]     frame_addr;
    logic [DATA_W-1:0]     frame_data;

    assign frame_addr = shift_q[ADDR_MSB:ADDR_LSB];
    assign frame_data = shift_q[DATA_W-1:0];

    logic clear_frame;
    logic take_bit;
    logic write_hit;
    logic length_err;

    // An nCS rise ends the frame, so an SCLK rise in the same cycle is not
    // counted. nCS edges in IDLE other than a frame start do nothing.
    always_comb begin
        clear_frame = 1'b0;
        take_bit    = 1'b0;
        write_hit   = 1'b0;
        length_err  = 1'b0;
        case (state_q)
            IDLE: begin
                clear_frame = frame_start;
            end
            SHIFT: begin
                if (ncs_rise) begin
                    if (cnt_q == CNT_W'(FRAME_BITS)) begin
                        write_hit = shift_q[RW_BIT] && (int'(frame_addr) <= MAX_ADDR);
                    end else begin
                        length_err = 1'b1;
                    end
                end else begin
                    take_bit = sclk_rise;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state_q == SHIFT);

    // -------------------------------------------------------------------------
    // Bit counter and shift register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (clear_frame) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (take_bit) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], copi_level};
            if (cnt_q != CNT_W'(CNT_SAT)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_valid  <= write_hit;
            frame_err <= length_err;
            if (write_hit) begin
                wr_addr <= frame_addr;
                wr_data <= frame_data;
            end
        end
    end

endmodule : spi_frame_rx

// File: tb/tb_spi_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_rx
//   Directed bench for spi_frame_rx. SCLK runs at clk/8 (4 clk low, 4 clk
//   high); inputs change on the falling edge of clk and outputs are observed
//   on the falling edge. A passive monitor logs every wr_valid / frame_err
//   sample so multi-cycle pulses and strobes that land during the next frame
//   are both visible to the scenario tasks.
// -----------------------------------------------------------------------------
module tb_spi_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk_in;
    logic       copi_in;
    logic       ncs_in;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    spi_frame_rx #(
        .SYNC_STAGES (2),
        .MAX_ADDR    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk_in   (sclk_in),
        .copi_in   (copi_in),
        .ncs_in    (ncs_in),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Cycle number, advanced on every active edge.
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor state
    int         v_cnt;
    int         e_cnt;
    int         idle_cnt;
    int         last_v_cyc;
    int         last_e_cyc;
    int         raise_cyc;
    logic [6:0] v_addr_q[$];
    logic [7:0] v_data_q[$];

    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            v_cnt++;
            last_v_cyc = cyc;
            v_addr_q.push_back(wr_addr);
            v_data_q.push_back(wr_data);
        end
        if (frame_err === 1'b1) begin
            e_cnt++;
            last_e_cyc = cyc;
        end
        if (busy !== 1'b1) idle_cnt++;
    end

    function automatic logic [6:0] strobe_addr(int idx);
        return (v_addr_q.size() > idx) ? v_addr_q[idx] : 7'bx;
    endfunction

    function automatic logic [7:0] strobe_data(int idx);
        return (v_data_q.size() > idx) ? v_data_q[idx] : 8'bx;
    endfunction

    task automatic clear_obs();
        v_cnt      = 0;
        e_cnt      = 0;
        idle_cnt   = 0;
        last_v_cyc = -100;
        last_e_cyc = -100;
        v_addr_q.delete();
        v_data_q.delete();
    endtask

    task automatic wait_clks(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        ncs_in = 1'b0;
        wait_clks(4);
    endtask

    // Clocks out bits[n-1:0] MSB first, then leaves SCLK low for 4 clk.
    task automatic clock_bits(logic [31:0] bits, int n);
        for (int i = n - 1; i >= 0; i--) begin
            sclk_in = 1'b0;
            copi_in = bits[i];
            wait_clks(4);
            sclk_in = 1'b1;
            wait_clks(4);
        end
        sclk_in = 1'b0;
        wait_clks(4);
    endtask

    task automatic end_frame();
        ncs_in    = 1'b1;
        raise_cyc = cyc;
        wait_clks(12);
        #1;
    endtask

    task automatic send_frame(logic [31:0] bits, int n);
        start_frame();
        clock_bits(bits, n);
        end_frame();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst     = 1'b1;
        sclk_in = 1'b0;
        copi_in = 1'b0;
        ncs_in  = 1'b1;
        wait_clks(3);
        #1;
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b, expected 0", wr_valid); end
        checks++; if (wr_addr !== 7'h00) begin errors++; $display("FAIL reset_wr_addr: got 0x%0h, expected 0x0", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got 0x%0h, expected 0x0", wr_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        wait_clks(6);
    endtask

    task automatic test_basic_write();
        clear_obs();
        start_frame();
        clock_bits(32'h80FF, 16);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_in_frame: got %b, expected 1", busy); end
        end_frame();
        checks++; if (v_cnt != 1) begin errors++; $display("FAIL basic_strobe_cycles: got %0d, expected 1", v_cnt); end
        checks++; if (strobe_addr(0) !== 7'h00) begin errors++; $display("FAIL basic_addr: got 0x%0h, expected 0x0", strobe_addr(0)); end
        checks++; if (strobe_data(0) !== 8'hFF) begin errors++; $display("FAIL basic_data: got 0x%0h, expected 0xff", strobe_data(0)); end
        checks++; if (e_cnt != 0) begin errors++; $display("FAIL basic_no_err: got %0d err cycles, expected 0", e_cnt); end
        checks++; if (last_v_cyc - raise_cyc != 3) begin errors++; $display("FAIL basic_latency: got %0d edges, expected 3", last_v_cyc - raise_cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b, expected 0", busy); end
    endtask

    task automatic test_write_then_read();
        clear_obs();
        send_frame(32'h84A5, 16);
        checks++; if (v_cnt != 1) begin errors++; $display("FAIL wr_strobe_cycles: got %0d, expected 1", v_cnt); end
        checks++; if (strobe_addr(0) !== 7'h04) begin errors++; $display("FAIL wr_addr: got 0x%0h, expected 0x4", strobe_addr(0)); end
        checks++; if (strobe_data(0) !== 8'hA5) begin errors++; $display("FAIL wr_data: got 0x%0h, expected 0xa5", strobe_data(0)); end
        clear_obs();
        send_frame(32'h0233, 16);
        checks++; if (v_cnt != 0) begin errors++; $display("FAIL read_no_strobe: got %0d, expected 0", v_cnt); end
        checks++; if (e_cnt != 0) begin errors++; $display("FAIL read_no_err: got %0d, expected 0", e_cnt); end
        checks++; if (wr_addr !== 7'h04) begin errors++; $display("FAIL read_addr_held: got 0x%0h, expected 0x4", wr_addr); end
        checks++; if (wr_data !== 8'hA5) begin errors++; $display("FAIL read_data_held: got 0x%0h, expected 0xa5", wr_data); end
    endtask

    task automatic test_bad_length();
        clear_obs();
        send_frame(32'h0000_0ABC, 12);
        checks++; if (e_cnt != 1) begin errors++; $display("FAIL short_err_cycles: got %0d, expected 1", e_cnt); end
        checks++; if (last_e_cyc - raise_cyc != 3) begin errors++; $display("FAIL short_err_latency: got %0d edges, expected 3", last_e_cyc - raise_cyc); end
        checks++; if (v_cnt != 0) begin errors++; $display("FAIL short_no_strobe: got %0d, expected 0", v_cnt); end
        clear_obs();
        send_frame(32'h0001_80AA, 17);
        checks++; if (e_cnt != 1) begin errors++; $display("FAIL long_err_cycles: got %0d, expected 1", e_cnt); end
        checks++; if (v_cnt != 0) begin errors++; $display("FAIL long_no_strobe: got %0d, expected 0", v_cnt); end
        clear_obs();
        send_frame(32'h0, 0);
        checks++; if (e_cnt != 1) begin errors++; $display("FAIL empty_err_cycles: got %0d, expected 1", e_cnt); end
        checks++; if (wr_addr !== 7'h04) begin errors++; $display("FAIL badlen_addr_held: got 0x%0h, expected 0x4", wr_addr); end
        checks++; if (wr_data !== 8'hA5) begin errors++; $display("FAIL badlen_data_held: got 0x%0h, expected 0xa5", wr_data); end
    endtask

    task automatic test_addr_range();
        clear_obs();
        send_frame(32'h8511, 16);
        checks++; if (v_cnt != 0) begin errors++; $display("FAIL range_no_strobe: got %0d, expected 0", v_cnt); end
        checks++; if (e_cnt != 0) begin errors++; $display("FAIL range_no_err: got %0d, expected 0", e_cnt); end
        checks++; if (wr_addr !== 7'h04) begin errors++; $display("FAIL range_addr_held: got 0x%0h, expected 0x4", wr_addr); end
    endtask

    task automatic test_reset_mid_frame();
        clear_obs();
        start_frame();
        clock_bits(32'h81, 8);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(6);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_after_rst: got %b, expected 0", busy); end
        checks++; if (wr_addr !== 7'h00) begin errors++; $display("FAIL midrst_addr_cleared: got 0x%0h, expected 0x0", wr_addr); end
        clock_bits(32'h33, 8);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_tail: got %b, expected 0", busy); end
        end_frame();
        checks++; if (v_cnt != 0) begin errors++; $display("FAIL midrst_no_strobe: got %0d, expected 0", v_cnt); end
        checks++; if (e_cnt != 0) begin errors++; $display("FAIL midrst_no_err: got %0d, expected 0", e_cnt); end
        clear_obs();
        send_frame(32'h8133, 16);
        checks++; if (v_cnt != 1) begin errors++; $display("FAIL midrst_next_strobe: got %0d, expected 1", v_cnt); end
        checks++; if (strobe_addr(0) !== 7'h01) begin errors++; $display("FAIL midrst_next_addr: got 0x%0h, expected 0x1", strobe_addr(0)); end
        checks++; if (strobe_data(0) !== 8'h33) begin errors++; $display("FAIL midrst_next_data: got 0x%0h, expected 0x33", strobe_data(0)); end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        start_frame();
        clock_bits(32'h8001, 16);
        idle_cnt  = 0;
        ncs_in    = 1'b1;
        raise_cyc = cyc;
        wait_clks(2);
        start_frame();
        #1;
        checks++; if (idle_cnt < 1) begin errors++; $display("FAIL b2b_busy_drop: got %0d idle cycles, expected at least 1", idle_cnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_started: got %b, expected 1", busy); end
        clock_bits(32'h8102, 16);
        end_frame();
        checks++; if (v_cnt != 2) begin errors++; $display("FAIL b2b_strobe_cycles: got %0d, expected 2", v_cnt); end
        checks++; if (strobe_addr(0) !== 7'h00) begin errors++; $display("FAIL b2b_addr0: got 0x%0h, expected 0x0", strobe_addr(0)); end
        checks++; if (strobe_data(0) !== 8'h01) begin errors++; $display("FAIL b2b_data0: got 0x%0h, expected 0x1", strobe_data(0)); end
        checks++; if (strobe_addr(1) !== 7'h01) begin errors++; $display("FAIL b2b_addr1: got 0x%0h, expected 0x1", strobe_addr(1)); end
        checks++; if (strobe_data(1) !== 8'h02) begin errors++; $display("FAIL b2b_data1: got 0x%0h, expected 0x2", strobe_data(1)); end
        checks++; if (e_cnt != 0) begin errors++; $display("FAIL b2b_no_err: got %0d, expected 0", e_cnt); end
    endtask

    initial begin
        clear_obs();
        raise_cyc = 0;
        test_reset();
        test_basic_write();
        test_write_then_read();
        test_bad_length();
        test_addr_range();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_spi_frame_rx
